// File: rtl/ws2812_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_frame_ctrl
// Brief    : Fetches a frame of GRB pixels from RAM and serialises it onto a
//            WS2812 LED chain, followed by the latch/reset idle period.
// Revision : 1.0 - initial release
// ============================================================================
module ws2812_frame_ctrl #(
  parameter int ADDR_W       = 8,
  parameter int SLOT_CYCLES  = 4,
  parameter int RESET_CYCLES = 720,
  parameter bit INVERT       = 1'b1
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_leds,
  output logic              pix_rd,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [23:0]       pix_data,
  output logic              busy,
  output logic              done,
  output logic              ws_out
);

  localparam int c_CYC_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int c_LAT_W = $clog2(RESET_CYCLES + 1);
  localparam logic [c_CYC_W-1:0] c_CYC_LAST = c_CYC_W'(SLOT_CYCLES - 1);
  localparam logic [c_LAT_W-1:0] c_LAT_LAST = c_LAT_W'(RESET_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_LATCH = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [c_CYC_W-1:0]  r_cyc;
  logic [1:0]          r_slot;
  logic [4:0]          r_bit;
  logic [ADDR_W-1:0]   r_pix_idx;
  logic [ADDR_W-1:0]   r_last_idx;
  logic [c_LAT_W-1:0]  r_lat;
  logic [23:0]         r_shift;
  logic [23:0]         r_prefetch;
  logic                r_pix_rd;
  logic                r_pix_rd_d;
  logic [ADDR_W-1:0]   r_pix_addr;
  logic                r_busy;
  logic                r_done;
  logic                r_ws;

  logic w_accept;
  logic w_slot_end;
  logic w_bit_end;
  logic w_pixel_end;
  logic w_last_pixel;
  logic w_prefetch;
  logic w_latch_end;
  logic w_level;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_slot_end   = (r_cyc == c_CYC_LAST);
    w_bit_end    = w_slot_end && (r_slot == 2'd3);
    w_pixel_end  = w_bit_end && (r_bit == 5'd23);
    w_last_pixel = (r_pix_idx == r_last_idx);
    w_prefetch   = (r_state == S_SHIFT) && (r_bit == 5'd0) && (r_slot == 2'd0) &&
                   (r_cyc == '0) && !w_last_pixel;
    w_latch_end  = (r_state == S_LATCH) && (r_lat == c_LAT_LAST);
    // Slot 0 always high, slot 1 carries the data bit, slots 2-3 low.
    w_level      = (r_state == S_SHIFT) &&
                   ((r_slot == 2'd0) || ((r_slot == 2'd1) && r_shift[23]));
    case (r_state)
      S_IDLE: begin
        // The done cycle is already IDLE but must still drop a start.
        if (start && !r_done) begin
          w_accept     = 1'b1;
          w_next_state = (num_leds == '0) ? S_LATCH : S_FETCH;
        end
      end
      S_FETCH: w_next_state = S_LOAD;
      S_LOAD:  w_next_state = S_SHIFT;
      S_SHIFT: if (w_pixel_end && w_last_pixel) w_next_state = S_LATCH;
      S_LATCH: if (w_latch_end) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc      <= '0;
      r_slot     <= '0;
      r_bit      <= '0;
      r_pix_idx  <= '0;
      r_last_idx <= '0;
      r_lat      <= '0;
      r_shift    <= '0;
      r_prefetch <= '0;
      r_pix_rd   <= 1'b0;
      r_pix_rd_d <= 1'b0;
      r_pix_addr <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ws       <= INVERT;
    end else begin
      r_pix_rd   <= 1'b0;
      r_pix_rd_d <= r_pix_rd;
      r_done     <= w_latch_end;
      r_ws       <= INVERT ^ w_level;
      if (w_accept) begin
        r_busy     <= 1'b1;
        r_last_idx <= num_leds - ADDR_W'(1);
        r_pix_idx  <= '0;
        r_lat      <= '0;
        if (num_leds != '0) begin
          r_pix_rd   <= 1'b1;
          r_pix_addr <= '0;
        end
      end
      if (w_latch_end) r_busy <= 1'b0;
      if (r_state == S_LOAD) begin
        r_shift <= pix_data;
        r_cyc   <= '0;
        r_slot  <= '0;
        r_bit   <= '0;
      end
      if (r_state == S_SHIFT) begin
        if (r_pix_rd_d) r_prefetch <= pix_data;
        if (w_prefetch) begin
          r_pix_rd   <= 1'b1;
          r_pix_addr <= r_pix_idx + ADDR_W'(1);
        end
        r_cyc <= w_slot_end ? '0 : r_cyc + c_CYC_W'(1);
        if (w_slot_end) r_slot <= r_slot + 2'd1;
        if (w_bit_end) begin
          if (r_bit == 5'd23) begin
            // Prefetched pixel drops in with no gap between pixels.
            r_bit     <= '0;
            r_shift   <= r_prefetch;
            r_pix_idx <= r_pix_idx + ADDR_W'(1);
            if (w_last_pixel) r_lat <= c_LAT_W'(1);
          end else begin
            r_bit   <= r_bit + 5'd1;
            r_shift <= {r_shift[22:0], 1'b0};
          end
        end
      end
      if (r_state == S_LATCH) r_lat <= r_lat + c_LAT_W'(1);
    end
  end

  assign pix_rd   = r_pix_rd;
  assign pix_addr = r_pix_addr;
  assign busy     = r_busy;
  assign done     = r_done;
  assign ws_out   = r_ws;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_frame_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ws2812_frame_ctrl
// Brief    : Scoreboard bench for ws2812_frame_ctrl (INVERT=1 and INVERT=0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ws2812_frame_ctrl;

  typedef struct {
    int hi;
    bit first;
  } exp_bit_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  num_leds = '0;
  logic        rd_a, rd_b, busy_a, busy_b, done_a, done_b, ws_a, ws_b;
  logic [7:0]  addr_a, addr_b;
  logic [23:0] data_a = '0;
  logic [23:0] data_b = '0;

  int checks = 0;
  int failures = 0;
  exp_bit_t exp_bits[$];
  int exp_addr[$];
  logic [23:0] mem [0:255];

  int  rd_count = 0;
  int  first_rise = -1;
  int  prev_rise = 0;
  int  rise_edge = 0;
  int  hi_cnt = 0;
  bit  line_prev = 1'b0;
  int  inv_samples = 0;
  int  inv_mism = 0;

  ws2812_frame_ctrl #(.ADDR_W(8), .SLOT_CYCLES(4), .RESET_CYCLES(720), .INVERT(1'b1)) u_dut_a (
    .clk_in(clk), .rst_n(rst_n), .start(start), .num_leds(num_leds),
    .pix_rd(rd_a), .pix_addr(addr_a), .pix_data(data_a),
    .busy(busy_a), .done(done_a), .ws_out(ws_a)
  );

  ws2812_frame_ctrl #(.ADDR_W(8), .SLOT_CYCLES(4), .RESET_CYCLES(720), .INVERT(1'b0)) u_dut_b (
    .clk_in(clk), .rst_n(rst_n), .start(start), .num_leds(num_leds),
    .pix_rd(rd_b), .pix_addr(addr_b), .pix_data(data_b),
    .busy(busy_b), .done(done_b), .ws_out(ws_b)
  );

  always #5 clk = ~clk;

  // Synchronous pixel RAM, one-cycle read latency
  always @(posedge clk) begin
    if (rd_a) data_a <= mem[addr_a];
    if (rd_b) data_b <= mem[addr_b];
  end

  function automatic int edge_now();
    return int'($time / 10) - 1;
  endfunction

  // Decode pulses on the (non-inverted) line and check against the scoreboard
  always @(negedge clk) begin
    bit line;
    exp_bit_t e;
    if (!rst_n) begin
      line_prev = 1'b0;
      hi_cnt    = 0;
    end else begin
      line = ~ws_a;
      if (line && !line_prev) begin
        rise_edge = edge_now();
        hi_cnt    = 1;
      end else if (line) begin
        hi_cnt++;
      end else if (line_prev) begin
        checks++;
        if (exp_bits.size() == 0) begin
          failures++;
          $display("FAIL bit_unexpected: pulse of %0d clks at edge %0d, none expected", hi_cnt, rise_edge);
        end else begin
          e = exp_bits.pop_front();
          if (hi_cnt !== e.hi) begin
            failures++;
            $display("FAIL bit_high_len: got=%0d exp=%0d at edge %0d", hi_cnt, e.hi, rise_edge);
          end
          if (!e.first) begin
            checks++;
            if (rise_edge - prev_rise !== 16) begin
              failures++;
              $display("FAIL bit_period: got=%0d exp=16 at edge %0d", rise_edge - prev_rise, rise_edge);
            end
          end else begin
            first_rise = rise_edge;
          end
          prev_rise = rise_edge;
        end
      end
      line_prev = line;
    end
  end

  always @(negedge clk) begin
    int ea;
    if (rst_n && rd_a) begin
      rd_count++;
      checks++;
      if (exp_addr.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected: pix_rd with addr=%0d, none expected", addr_a);
      end else begin
        ea = exp_addr.pop_front();
        if (int'(addr_a) !== ea) begin
          failures++;
          $display("FAIL rd_addr: got=%0d exp=%0d", addr_a, ea);
        end
      end
    end
  end

  always @(negedge clk) begin
    inv_samples++;
    if (ws_a !== ~ws_b) inv_mism++;
  end

  task automatic push_frame(input int n);
    exp_bit_t eb;
    logic [23:0] w;
    for (int p = 0; p < n; p++) begin
      exp_addr.push_back(p);
      w = mem[p];
      for (int b = 23; b >= 0; b--) begin
        eb.hi    = w[b] ? 8 : 4;
        eb.first = (p == 0) && (b == 23);
        exp_bits.push_back(eb);
      end
    end
  endtask

  task automatic pulse_start(input int n, output int t);
    @(negedge clk);
    num_leds = 8'(n);
    start    = 1'b1;
    @(posedge clk);
    t = int'(($time - 5) / 10);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int d);
    d = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_a) begin
        d = edge_now();
        break;
      end
    end
    if (d < 0) $display("FAIL done_timeout: no done within %0d cycles", budget);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL rst_busy: got=%b exp=0", busy_a); end
    checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL rst_done: got=%b exp=0", done_a); end
    checks++; if (rd_a !== 1'b0) begin failures++; $display("FAIL rst_pix_rd: got=%b exp=0", rd_a); end
    checks++; if (addr_a !== 8'd0) begin failures++; $display("FAIL rst_pix_addr: got=%0d exp=0", addr_a); end
    checks++; if (ws_a !== 1'b1) begin failures++; $display("FAIL rst_ws_inv1: got=%b exp=1", ws_a); end
    checks++; if (ws_b !== 1'b0) begin failures++; $display("FAIL rst_ws_inv0: got=%b exp=0", ws_b); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || ws_a !== 1'b1) begin
      failures++;
      $display("FAIL idle_after_rst: busy=%b ws=%b exp busy=0 ws=1", busy_a, ws_a);
    end
  endtask

  task automatic test_single();
    int t, d, rd0;
    mem[0] = 24'hFF0000;
    push_frame(1);
    first_rise = -1;
    rd0 = rd_count;
    pulse_start(1, t);
    wait_done(3000, d);
    checks++; if (d !== t + 1106) begin failures++; $display("FAIL single_done_edge: got=%0d exp=%0d", d - t, 1106); end
    checks++; if (first_rise - t !== 3) begin failures++; $display("FAIL single_first_rise: got=%0d exp=3", first_rise - t); end
    checks++; if (rd_count - rd0 !== 1) begin failures++; $display("FAIL single_rd_count: got=%0d exp=1", rd_count - rd0); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL single_busy_at_done: got=%b exp=0", busy_a); end
    @(negedge clk);
    checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL single_done_width: got=%b exp=0", done_a); end
    checks++;
    if (exp_bits.size() != 0 || exp_addr.size() != 0) begin
      failures++;
      $display("FAIL single_leftover: bits=%0d addrs=%0d exp=0", exp_bits.size(), exp_addr.size());
    end
  endtask

  task automatic test_multi();
    int t, d, rd0;
    mem[0] = 24'h010203;
    mem[1] = 24'h808080;
    mem[2] = 24'hFFFFFF;
    push_frame(3);
    rd0 = rd_count;
    pulse_start(3, t);
    wait_done(4000, d);
    checks++; if (d !== t + 1874) begin failures++; $display("FAIL multi_done_edge: got=%0d exp=1874", d - t); end
    checks++; if (rd_count - rd0 !== 3) begin failures++; $display("FAIL multi_rd_count: got=%0d exp=3", rd_count - rd0); end
    checks++;
    if (exp_bits.size() != 0 || exp_addr.size() != 0) begin
      failures++;
      $display("FAIL multi_leftover: bits=%0d addrs=%0d exp=0", exp_bits.size(), exp_addr.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_zero();
    int t, d, rd0, bcnt, wsbad;
    rd0   = rd_count;
    bcnt  = 0;
    wsbad = 0;
    d     = -1;
    pulse_start(0, t);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (busy_a) bcnt++;
      if (ws_a !== 1'b1) wsbad++;
      if (done_a) begin d = edge_now(); break; end
    end
    checks++; if (d !== t + 721) begin failures++; $display("FAIL zero_done_edge: got=%0d exp=721", d - t); end
    checks++; if (bcnt !== 721) begin failures++; $display("FAIL zero_busy_cycles: got=%0d exp=721", bcnt); end
    checks++; if (rd_count !== rd0) begin failures++; $display("FAIL zero_rd: got=%0d exp=0", rd_count - rd0); end
    checks++; if (wsbad !== 0) begin failures++; $display("FAIL zero_line_idle: got=%0d non-idle samples exp=0", wsbad); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int t, d, t2, d2, rd0;
    mem[0] = 24'hA5C30F;
    mem[1] = 24'h3C5A96;
    push_frame(2);
    rd0 = rd_count;
    d   = -1;
    pulse_start(2, t);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (edge_now() == t + 100) begin start = 1'b1; num_leds = 8'd5; end
      else start = 1'b0;
      if (done_a) begin d = edge_now(); break; end
    end
    checks++; if (d !== t + 1490) begin failures++; $display("FAIL b2b_done_edge: got=%0d exp=1490", d - t); end
    checks++; if (rd_count - rd0 !== 2) begin failures++; $display("FAIL b2b_rd_count: got=%0d exp=2", rd_count - rd0); end
    // Start held across the done cycle: dropped there, accepted one cycle later
    mem[0] = 24'h00FF00;
    push_frame(1);
    num_leds = 8'd1;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL b2b_start_on_done: busy got=%b exp=0", busy_a); end
    @(posedge clk);
    t2 = int'(($time - 5) / 10);
    #1 start = 1'b0;
    @(negedge clk);
    checks++; if (busy_a !== 1'b1 || t2 !== d + 2) begin failures++; $display("FAIL b2b_accept: busy=%b edge=%0d exp busy=1 edge=%0d", busy_a, t2 - d, 2); end
    wait_done(3000, d2);
    checks++; if (d2 !== t2 + 1106) begin failures++; $display("FAIL b2b_second_done: got=%0d exp=1106", d2 - t2); end
    checks++;
    if (exp_bits.size() != 0 || exp_addr.size() != 0) begin
      failures++;
      $display("FAIL b2b_leftover: bits=%0d addrs=%0d exp=0", exp_bits.size(), exp_addr.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int t, d, rd0;
    bit saw_done;
    mem[0] = 24'h123456;
    mem[1] = 24'hFEDCBA;
    push_frame(2);
    pulse_start(2, t);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (edge_now() >= t + 549) break;
    end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (ws_a !== 1'b1 || ws_b !== 1'b0) begin failures++; $display("FAIL mid_rst_ws: a=%b b=%b exp a=1 b=0", ws_a, ws_b); end
    checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin failures++; $display("FAIL mid_rst_flags: busy=%b done=%b exp 0 0", busy_a, done_a); end
    checks++; if (exp_bits.size() !== 14) begin failures++; $display("FAIL mid_rst_bits_sent: remaining got=%0d exp=14", exp_bits.size()); end
    exp_bits.delete();
    exp_addr.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (800) begin
      @(negedge clk);
      if (done_a) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL mid_rst_no_done: got=1 exp=0"); end
    mem[0] = 24'h0F0F0F;
    mem[1] = 24'hF0F0F0;
    push_frame(2);
    rd0 = rd_count;
    first_rise = -1;
    pulse_start(2, t);
    wait_done(4000, d);
    checks++; if (d !== t + 1490) begin failures++; $display("FAIL mid_rst_refr_done: got=%0d exp=1490", d - t); end
    checks++; if (first_rise - t !== 3) begin failures++; $display("FAIL mid_rst_first_rise: got=%0d exp=3", first_rise - t); end
    checks++; if (rd_count - rd0 !== 2) begin failures++; $display("FAIL mid_rst_rd_count: got=%0d exp=2", rd_count - rd0); end
    checks++;
    if (exp_bits.size() != 0 || exp_addr.size() != 0) begin
      failures++;
      $display("FAIL mid_rst_leftover: bits=%0d addrs=%0d exp=0", exp_bits.size(), exp_addr.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_invert();
    checks++;
    if (inv_mism !== 0 || inv_samples < 1000) begin
      failures++;
      $display("FAIL invert_complement: mismatching samples=%0d of %0d exp=0", inv_mism, inv_samples);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset();
    test_single();
    test_multi();
    test_zero();
    test_back_to_back();
    test_reset_mid();
    test_invert();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
